ex_mem_pipe: RTL

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_pipe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe
//   EX -> MEM pipeline register built as a 2-entry in-order buffer (head +
//   skid). It breaks the ready path: ex_ready depends only on registered
//   occupancy, never on mem_ready. Writes to register 0 are neutralised on
//   capture. Outputs are forced to zero when no entry is held, so a bubble
//   never commits a register write.
//
// Parameters
//   DATA_W  width of one write-data channel
//   REG_AW  width of one register-address channel
//   NCH     number of independent write-back channels (1..4)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous discard of all held entries (beats accept/pop)
//   ex_valid   EX offers an entry
//   ex_ready   buffer has room (occupancy < 2)
//   ex_waddr   per-channel destination register, channel i at [i*REG_AW +: REG_AW]
//   ex_wdata   per-channel write data, packed like ex_waddr
//   ex_wreg    per-channel write enable
//   mem_valid  head entry present
//   mem_ready  MEM consumes the head entry this cycle
//   mem_waddr  head entry register addresses (zero when empty)
//   mem_wdata  head entry write data (zero when empty)
//   mem_wreg   head entry write enables (zero when empty)
//   occupancy  number of held entries, 0..2
// ---------------------------------------------------------------------------
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NCH    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [NCH*REG_AW-1:0] ex_waddr,
  input  logic [NCH*DATA_W-1:0] ex_wdata,
  input  logic [NCH-1:0]        ex_wreg,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [NCH*REG_AW-1:0] mem_waddr,
  output logic [NCH*DATA_W-1:0] mem_wdata,
  output logic [NCH-1:0]        mem_wreg,
  output logic [1:0]            occupancy
);

  // The fill level is the only control state; its encoding equals the count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e state, state_next;

  logic load_head;
  logic load_skid;
  logic skid_to_head;
  logic accept;
  logic pop;

  logic [NCH-1:0] cap_wreg;

  logic [NCH*REG_AW-1:0] head_waddr, skid_waddr;
  logic [NCH*DATA_W-1:0] head_wdata, skid_wdata;
  logic [NCH-1:0]        head_wreg,  skid_wreg;

  assign ex_ready  = (state != OCC_FULL);
  assign mem_valid = (state != OCC_EMPTY);
  assign occupancy = state;
  assign accept    = ex_valid & ex_ready;
  assign pop       = mem_valid & mem_ready;

  // A write to register 0 is architecturally a no-op, so drop its enable
  // before storing; address and data are kept as presented.
  always_comb begin
    cap_wreg = '0;
    for (int i = 0; i < NCH; i++) begin
      cap_wreg[i] = ex_wreg[i] & (|ex_waddr[i*REG_AW +: REG_AW]);
    end
  end

  // Fill-level register; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= OCC_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next fill level and which storage slot gets written. When a push and a
  // pop coincide at one entry, the newcomer lands directly in head so the
  // skid slot is only used when MEM is stalling.
  always_comb begin
    state_next   = state;
    load_head    = 1'b0;
    load_skid    = 1'b0;
    skid_to_head = 1'b0;
    if (flush) begin
      state_next = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (accept) begin
            state_next = OCC_ONE;
            load_head  = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            load_head = 1'b1;
          end else if (accept) begin
            state_next = OCC_FULL;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            state_next   = OCC_ONE;
            skid_to_head = 1'b1;
          end
        end
        default: begin
          state_next = OCC_EMPTY;
        end
      endcase
    end
  end

  // Entry storage. Stale contents left after a pop or flush are harmless
  // because the outputs are masked by mem_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_waddr <= '0;
      head_wdata <= '0;
      head_wreg  <= '0;
      skid_waddr <= '0;
      skid_wdata <= '0;
      skid_wreg  <= '0;
    end else begin
      if (load_head) begin
        head_waddr <= ex_waddr;
        head_wdata <= ex_wdata;
        head_wreg  <= cap_wreg;
      end else if (skid_to_head) begin
        head_waddr <= skid_waddr;
        head_wdata <= skid_wdata;
        head_wreg  <= skid_wreg;
      end
      if (load_skid) begin
        skid_waddr <= ex_waddr;
        skid_wdata <= ex_wdata;
        skid_wreg  <= cap_wreg;
      end
    end
  end

  // A bubble presents all-zero fields; gating by the registered count keeps
  // mem_wreg glitch-free when reset hits mid-transfer.
  always_comb begin
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wreg  = '0;
    if (mem_valid) begin
      mem_waddr = head_waddr;
      mem_wdata = head_wdata;
      mem_wreg  = head_wreg;
    end
  end

endmodule
